// File: rtl/atm_bank_host.sv
// Bank-side responder for the ATM: validates PIN/session, applies balance ops, replies status+balance.
// Optional per-session debit limit is compiled in with `define WITHDRAW_LIMIT_EN.
module atm_bank_host #(
    parameter int              ACCOUNTS     = 4,
    parameter int              AMT_W        = 32,
    parameter logic [AMT_W-1:0] INIT_BALANCE = 32'h000186A0,
    parameter logic [3:0]      INIT_PIN     = 4'b1110,
    parameter int              MAX_TRIES    = 3,
    parameter logic [AMT_W-1:0] WD_LIMIT     = 32'd20000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [1:0]       req_acct,
    input  logic [1:0]       req_dst_acct,
    input  logic [3:0]       req_pin,
    input  logic [AMT_W-1:0] req_amount,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [2:0]       rsp_status,
    output logic [AMT_W-1:0] rsp_balance
);
    typedef enum logic [1:0] {S_IDLE, S_CHECK, S_UPDATE, S_RESPOND} state_t;

    localparam logic [2:0] OP_VERIFY = 3'd0, OP_BALANCE = 3'd1, OP_WITHDRAW = 3'd2,
                           OP_DEPOSIT = 3'd3, OP_TRANSFER = 3'd4, OP_END = 3'd5;
    localparam logic [2:0] ST_OK = 3'd0, ST_BAD_PIN = 3'd1, ST_LOCKED = 3'd2, ST_INSUFF = 3'd3,
                           ST_NO_SESS = 3'd4, ST_BAD_OP = 3'd5, ST_OVERFLOW = 3'd6, ST_LIMIT = 3'd7;
    localparam logic [1:0] MAX_T = 2'(MAX_TRIES);

    state_t              state_q;
    logic [2:0]          op_q;
    logic [1:0]          acct_q, dst_q, sess_acct_q;
    logic [3:0]          pin_q;
    logic [AMT_W-1:0]    amt_q, new_src_q, new_dst_q, rbal_q;
    logic [AMT_W-1:0]    bal_q  [ACCOUNTS];
    logic [3:0]          pins_q [ACCOUNTS];
    logic [1:0]          tries_q[ACCOUNTS];
    logic [ACCOUNTS-1:0] locked_q;
    logic                sess_open_q;
    logic [2:0]          status_q;
    logic                req_ready_q, rsp_valid_q;
    logic [2:0]          rsp_status_q;
    logic [AMT_W-1:0]    rsp_balance_q;
    logic [AMT_W:0]      accum_q;

    logic [2:0]          status_d;
    logic [AMT_W-1:0]    src_bal_s, dst_bal_s, new_src_d, new_dst_d, rbal_d;
    logic [AMT_W:0]      dep_sum_s, xfer_sum_s;
    logic [AMT_W+1:0]    lim_sum_s;
    logic                sess_ok_s, lim_hit_s;

    assign req_ready   = req_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_status  = rsp_status_q;
    assign rsp_balance = rsp_balance_q;

    // Evaluate the latched request against current account state.
    always_comb begin
        src_bal_s  = bal_q[acct_q];
        dst_bal_s  = bal_q[dst_q];
        sess_ok_s  = sess_open_q && (sess_acct_q == acct_q);
        dep_sum_s  = {1'b0, src_bal_s} + {1'b0, amt_q};
        xfer_sum_s = {1'b0, dst_bal_s} + {1'b0, amt_q};
        lim_sum_s  = {1'b0, accum_q} + {2'b00, amt_q};
`ifdef WITHDRAW_LIMIT_EN
        lim_hit_s  = lim_sum_s > {2'b00, WD_LIMIT};
`else
        lim_hit_s  = 1'b0;
`endif
        status_d  = ST_OK;
        new_src_d = src_bal_s;
        new_dst_d = dst_bal_s;
        case (op_q)
            OP_VERIFY: begin
                if (locked_q[acct_q])              status_d = ST_LOCKED;
                else if (pin_q != pins_q[acct_q]) status_d = ST_BAD_PIN;
                else                              status_d = ST_OK;
            end
            OP_BALANCE, OP_END: begin
                if (!sess_ok_s) status_d = ST_NO_SESS;
                else            status_d = ST_OK;
            end
            OP_WITHDRAW: begin
                if (!sess_ok_s)              status_d = ST_NO_SESS;
                else if (amt_q > src_bal_s) status_d = ST_INSUFF;
                else if (lim_hit_s)         status_d = ST_LIMIT;
                else                        new_src_d = src_bal_s - amt_q;
            end
            OP_DEPOSIT: begin
                if (!sess_ok_s)          status_d = ST_NO_SESS;
                else if (dep_sum_s[AMT_W]) status_d = ST_OVERFLOW;
                else                     new_src_d = dep_sum_s[AMT_W-1:0];
            end
            OP_TRANSFER: begin
                if (!sess_ok_s)               status_d = ST_NO_SESS;
                else if (dst_q == acct_q)     status_d = ST_BAD_OP;
                else if (amt_q > src_bal_s)   status_d = ST_INSUFF;
                else if (lim_hit_s)           status_d = ST_LIMIT;
                else if (xfer_sum_s[AMT_W])   status_d = ST_OVERFLOW;
                else begin
                    new_src_d = src_bal_s - amt_q;
                    new_dst_d = xfer_sum_s[AMT_W-1:0];
                end
            end
            default: status_d = ST_BAD_OP;
        endcase
        case (status_d)
            ST_OK:                                       rbal_d = new_src_d;
            ST_BAD_PIN, ST_LOCKED, ST_NO_SESS, ST_BAD_OP: rbal_d = '0;
            default:                                     rbal_d = src_bal_s;
        endcase
    end

    // Transaction FSM, account storage and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            op_q          <= 3'd0;
            acct_q        <= 2'd0;
            dst_q         <= 2'd0;
            pin_q         <= 4'd0;
            amt_q         <= '0;
            new_src_q     <= '0;
            new_dst_q     <= '0;
            rbal_q        <= '0;
            status_q      <= 3'd0;
            for (int i = 0; i < ACCOUNTS; i++) begin
                bal_q[i]   <= INIT_BALANCE;
                pins_q[i]  <= INIT_PIN;
                tries_q[i] <= 2'd0;
            end
            locked_q      <= '0;
            sess_open_q   <= 1'b0;
            sess_acct_q   <= 2'd0;
            accum_q       <= '0;
            req_ready_q   <= 1'b1;
            rsp_valid_q   <= 1'b0;
            rsp_status_q  <= 3'd0;
            rsp_balance_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid && req_ready_q) begin
                        op_q        <= req_op;
                        acct_q      <= req_acct;
                        dst_q       <= req_dst_acct;
                        pin_q       <= req_pin;
                        amt_q       <= req_amount;
                        req_ready_q <= 1'b0;
                        state_q     <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    status_q  <= status_d;
                    new_src_q <= new_src_d;
                    new_dst_q <= new_dst_d;
                    rbal_q    <= rbal_d;
                    lim_sum_hold(lim_sum_s);
                    state_q   <= S_UPDATE;
                end
                S_UPDATE: begin
                    if (status_q == ST_OK) begin
                        case (op_q)
                            OP_VERIFY: begin
                                tries_q[acct_q] <= 2'd0;
                                sess_open_q     <= 1'b1;
                                sess_acct_q     <= acct_q;
                                accum_q         <= '0;
                            end
                            OP_WITHDRAW: begin
                                bal_q[acct_q] <= new_src_q;
                                accum_q       <= accum_q + {1'b0, amt_q};
                            end
                            OP_DEPOSIT: bal_q[acct_q] <= new_src_q;
                            OP_TRANSFER: begin
                                bal_q[acct_q] <= new_src_q;
                                bal_q[dst_q]  <= new_dst_q;
                                accum_q       <= accum_q + {1'b0, amt_q};
                            end
                            OP_END: begin
                                sess_open_q <= 1'b0;
                                accum_q     <= '0;
                            end
                            default: ;
                        endcase
                    end else if (status_q == ST_BAD_PIN) begin
                        tries_q[acct_q] <= tries_q[acct_q] + 2'd1;
                        if (tries_q[acct_q] + 2'd1 >= MAX_T) locked_q[acct_q] <= 1'b1;
                    end
                    state_q <= S_RESPOND;
                end
                S_RESPOND: begin
                    if (!rsp_valid_q) begin
                        rsp_valid_q   <= 1'b1;
                        rsp_status_q  <= status_q;
                        rsp_balance_q <= rbal_q;
                    end else if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Sink so the limit sum is always consumed in the default build.
    function automatic void lim_sum_hold(input logic [AMT_W+1:0] v);
        logic unused;
        unused = ^v;
    endfunction
endmodule

// File: tb/tb_atm_bank_host.sv
// Randomized + directed bench for atm_bank_host against an arithmetic account model.
// Honours WITHDRAW_LIMIT_EN the same way the design does.
module tb_atm_bank_host;
    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, rsp_valid, rsp_ready;
    logic [2:0]  req_op, rsp_status;
    logic [1:0]  req_acct, req_dst_acct;
    logic [3:0]  req_pin;
    logic [31:0] req_amount, rsp_balance;

    int errs = 0;
    int checks = 0;

    longint unsigned m_bal[4];
    int              m_tries[4];
    bit              m_lock[4];
    bit              m_open;
    int              m_sess;
    longint unsigned m_acc;

    localparam longint unsigned MAXV = 64'h0000_0000_FFFF_FFFF;

    atm_bank_host dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_acct(req_acct), .req_dst_acct(req_dst_acct), .req_pin(req_pin),
        .req_amount(req_amount), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_status(rsp_status), .rsp_balance(rsp_balance)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_bal[i] = 100000; m_tries[i] = 0; m_lock[i] = 1'b0;
        end
        m_open = 1'b0; m_sess = 0; m_acc = 0;
    endtask

    function automatic bit over_limit(input longint unsigned amt);
`ifdef WITHDRAW_LIMIT_EN
        return (m_acc + amt) > 20000;
`else
        return 1'b0;
`endif
    endfunction

    // Applies one request to the model; returns expected status and balance.
    task automatic model_step(input int op, input int a, input int d, input int pin,
                              input longint unsigned amt, output int st, output longint unsigned bal);
        st = 0; bal = m_bal[a];
        if (op > 5) begin st = 5; bal = 0; end
        else if (op == 0) begin
            if (m_lock[a]) begin st = 2; bal = 0; end
            else if (pin == 4'b1110) begin
                m_tries[a] = 0; m_open = 1; m_sess = a; m_acc = 0;
            end else begin
                st = 1; bal = 0; m_tries[a]++;
                if (m_tries[a] >= 3) m_lock[a] = 1;
            end
        end
        else if (!(m_open && m_sess == a)) begin st = 4; bal = 0; end
        else if (op == 2) begin
            if (amt > m_bal[a]) st = 3;
            else if (over_limit(amt)) st = 7;
            else begin m_bal[a] -= amt; m_acc += amt; bal = m_bal[a]; end
        end
        else if (op == 3) begin
            if (m_bal[a] + amt > MAXV) st = 6;
            else begin m_bal[a] += amt; bal = m_bal[a]; end
        end
        else if (op == 4) begin
            if (d == a) begin st = 5; bal = 0; end
            else if (amt > m_bal[a]) st = 3;
            else if (over_limit(amt)) st = 7;
            else if (m_bal[d] + amt > MAXV) st = 6;
            else begin m_bal[a] -= amt; m_bal[d] += amt; m_acc += amt; bal = m_bal[a]; end
        end
        else if (op == 5) begin m_open = 0; m_acc = 0; end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    // Issues a request, checks latency, stall stability, status and balance.
    task automatic txn(input string tag, input int op, input int a, input int d, input int pin,
                       input longint unsigned amt, input int hold);
        int st; longint unsigned bal; int w; int lat;
        model_step(op, a, d, pin, amt, st, bal);
        @(negedge clk);
        w = 0;
        while (!req_ready && w < 50) begin @(negedge clk); w++; end
        if (w >= 50) check({tag, "_rdy_timeout"}, req_ready, 1);
        req_op = op[2:0]; req_acct = a[1:0]; req_dst_acct = d[1:0];
        req_pin = pin[3:0]; req_amount = amt[31:0];
        req_valid = 1'b1; rsp_ready = (hold == 0);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            if (req_ready) check({tag, "_busy_ready"}, req_ready, 0);
            @(negedge clk); lat++;
        end
        check({tag, "_latency"}, lat, 3);
        for (int k = 0; k < hold; k++) begin
            check({tag, "_hold_valid"}, rsp_valid, 1);
            check({tag, "_hold_status"}, rsp_status, st);
            check({tag, "_hold_ready"}, req_ready, 0);
            @(negedge clk);
        end
        check({tag, "_status"}, rsp_status, st);
        check({tag, "_balance"}, rsp_balance, bal);
        rsp_ready = 1'b1;
        @(negedge clk);
        check({tag, "_consumed"}, rsp_valid, 0);
    endtask

    initial begin
        int op, a, d, pin, h;
        longint unsigned amt;
        reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b1;
        req_op = 3'd0; req_acct = 2'd0; req_dst_acct = 2'd0; req_pin = 4'd0; req_amount = 32'd0;
        do_reset();
        check("rst_ready", req_ready, 1);
        check("rst_valid", rsp_valid, 0);
        check("rst_status", rsp_status, 0);
        check("rst_balance", rsp_balance, 0);

        txn("verify0", 0, 0, 0, 4'b1110, 0, 0);
        for (int i = 0; i < 3; i++) txn("badpin1", 0, 1, 0, 4'b0000, 0, 0);
        txn("locked1", 0, 1, 0, 4'b1110, 0, 0);
        do_reset();
        txn("unlock1", 0, 1, 0, 4'b1110, 0, 0);

        txn("v0", 0, 0, 0, 4'b1110, 0, 0);
        txn("wd_all", 2, 0, 0, 0, 100000, 0);
        txn("wd_insuff", 2, 0, 0, 0, 1, 0);
        txn("dep_max", 3, 0, 0, 0, 64'hFFFFFFFF, 0);
        txn("dep_ovf", 3, 0, 0, 0, 1, 0);
        txn("end0", 5, 0, 0, 0, 0, 0);
        txn("badop", 7, 0, 0, 0, 0, 0);

        txn("v2", 0, 2, 0, 4'b1110, 0, 0);
        txn("xfer", 4, 2, 3, 0, 5000, 0);
        txn("xfer_self", 4, 2, 2, 0, 5000, 0);
        txn("bal3_nosess", 1, 3, 0, 0, 0, 0);
        txn("stall", 1, 2, 0, 0, 0, 10);

        // Reset lands on the UPDATE cycle of a withdraw: no write, no response.
        do_reset();
        txn("v0b", 0, 0, 0, 4'b1110, 0, 0);
        @(negedge clk);
        req_op = 3'd2; req_acct = 2'd0; req_amount = 32'd500; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        for (int k = 0; k < 5; k++) begin
            check("rst_mid_novalid", rsp_valid, 0);
            @(negedge clk);
        end
        txn("rst_mid_v", 0, 0, 0, 4'b1110, 0, 0);
        txn("rst_mid_bal", 1, 0, 0, 0, 0, 0);

`ifdef WITHDRAW_LIMIT_EN
        txn("lim_wd1", 2, 0, 0, 0, 15000, 0);
        txn("lim_wd2", 2, 0, 0, 0, 6000, 0);
        txn("lim_end", 5, 0, 0, 0, 0, 0);
        txn("lim_v", 0, 0, 0, 4'b1110, 0, 0);
        txn("lim_wd3", 2, 0, 0, 0, 6000, 0);
`endif

        for (int n = 0; n < 250; n++) begin
            if ($urandom_range(0, 59) == 0) do_reset();
            op  = ($urandom_range(0, 9) < 2) ? 0 : int'($urandom_range(0, 7));
            a   = $urandom_range(0, 3);
            d   = $urandom_range(0, 3);
            pin = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 15)) : 4'b1110;
            case ($urandom_range(0, 3))
                0: amt = $urandom_range(0, 30000);
                1: amt = m_bal[a];
                2: amt = {32'd0, $urandom()};
                default: amt = MAXV - m_bal[a] + $urandom_range(0, 1);
            endcase
            if (amt > MAXV) amt = MAXV;
            h = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 3)) : 0;
            txn("rand", op, a, d, pin, amt, h);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
